addr_sweep_gen: RTL and testbench

- Initiator side of the registered address/enable interface into the pll_clock test datapath.
- On a start command, sweeps a contiguous block of operand-RAM read addresses with a read enable.
- Replays the same address/enable stream as a result-RAM write stream, delayed by the datapath latency.
- Reports busy/done to the Avalon-side control registers.

---
 rtl/addr_sweep_gen_pkg.sv | 17 +
 rtl/addr_sweep_gen_delay_line.sv | 50 +++++
 rtl/addr_sweep_gen.sv | 140 ++++++++++++++
 tb/tb_addr_sweep_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_sweep_gen_pkg.sv
// Shared definitions for the address sweep generator and the Avalon-side
// control-register block that reports its state.
//   sweep_state_t : FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   LAT_MIN/MAX   : legal range of the read-to-write datapath latency
package addr_sweep_gen_pkg;

    typedef enum logic [1:0] {
        SWEEP_IDLE  = 2'd0,
        SWEEP_RUN   = 2'd1,
        SWEEP_DRAIN = 2'd2,
        SWEEP_DONE  = 2'd3
    } sweep_state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 64;

endpackage

// File: rtl/addr_sweep_gen_delay_line.sv
// sweep_delay_line: DEPTH-stage register chain carrying {enable, address}.
//   pll_clock : clock
//   reset_n   : asynchronous active-low reset, clears every stage
//   in_e      : enable entering the chain
//   in_addr   : address entering the chain
//   out_e     : in_e delayed DEPTH cycles
//   out_addr  : in_addr delayed DEPTH cycles, held while out_e is low
module sweep_delay_line #(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 8
) (
    input  logic                  pll_clock,
    input  logic                  reset_n,
    input  logic                  in_e,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_e,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    // Kept as discrete flops so each stage can be placed next to its
    // neighbour; the async reset also rules out shift-register primitives.
    (* shreg_extract = "no" *) logic [DEPTH-1:0]      e_q;
    (* shreg_extract = "no" *) logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    // An address only advances alongside its enable, so a bubble in the
    // stream leaves the previous address standing at the output.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            e_q[0] <= in_e;
            if (in_e) begin
                addr_q[0] <= in_addr;
            end
            for (int i = 1; i < DEPTH; i++) begin
                e_q[i] <= e_q[i-1];
                if (e_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end
    end

    assign out_e    = e_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/addr_sweep_gen.sv
// addr_sweep_gen: sweeps operand-RAM read addresses 0..N-1 on start and
// replays the stream LATENCY cycles later as result-RAM writes.
//   pll_clock : clock
//   reset_n   : asynchronous active-low reset
//   start     : launch request, accepted in IDLE/DONE only
//   num_ops   : sweep length, clamped to 2^ADDR_WIDTH, sampled with start
//   abort     : ends read issue early while in RUN
//   rd_addr   : operand read address      rd_e : operand read enable
//   wr_addr   : result write address      wr_e : result write enable
//   busy      : RUN or DRAIN              done : sticky completion flag
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | issuing one read address per cycle
// DRAIN | reads finished, waiting LATENCY cycles for writes to emerge
// DONE  | sweep complete, done held until next accepted start
module addr_sweep_gen
    import addr_sweep_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 8
) (
    input  logic                  pll_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_ops,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_e,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_e,
    output logic                  busy,
    output logic                  done
);

    localparam int                  DRAIN_W    = $clog2(LAT_MAX);
    localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] MAX_OPS    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_OPS    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    sweep_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0]  rd_addr_nxt;
    logic                   rd_e_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;
    // Reads still to issue after the current one; terminal count is zero.
    logic [ADDR_WIDTH-1:0]  remain, remain_nxt;
    logic [DRAIN_W-1:0]     drain_cnt, drain_cnt_nxt;
    logic [ADDR_WIDTH:0]    n_req;
    logic [ADDR_WIDTH:0]    n_last;

    assign n_req  = (num_ops > MAX_OPS) ? MAX_OPS : num_ops;
    assign n_last = n_req - ONE_OPS;

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SWEEP_IDLE;
            rd_addr   <= '0;
            rd_e      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remain    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rd_addr   <= rd_addr_nxt;
            rd_e      <= rd_e_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            remain    <= remain_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rd_addr_nxt   = rd_addr;
        rd_e_nxt      = 1'b0;
        busy_nxt      = busy;
        done_nxt      = done;
        remain_nxt    = remain;
        drain_cnt_nxt = drain_cnt;

        case (state)
            SWEEP_IDLE, SWEEP_DONE: begin
                if (start) begin
                    if (n_req == '0) begin
                        state_nxt = SWEEP_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = SWEEP_RUN;
                        done_nxt    = 1'b0;
                        busy_nxt    = 1'b1;
                        rd_e_nxt    = 1'b1;
                        rd_addr_nxt = '0;
                        remain_nxt  = n_last[ADDR_WIDTH-1:0];
                    end
                end
            end
            SWEEP_RUN: begin
                // The address on the bus this cycle is the last one when
                // either the count runs out or abort is seen.
                if (abort || remain == '0) begin
                    state_nxt     = SWEEP_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else begin
                    rd_e_nxt    = 1'b1;
                    rd_addr_nxt = rd_addr + ONE_ADDR;
                    remain_nxt  = remain - ONE_ADDR;
                end
            end
            SWEEP_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = SWEEP_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = SWEEP_IDLE;
            end
        endcase
    end

    sweep_delay_line #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (LATENCY)
    ) u_delay_line (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .in_e      (rd_e),
        .in_addr   (rd_addr),
        .out_e     (wr_e),
        .out_addr  (wr_addr)
    );

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Scoreboard bench for addr_sweep_gen. Accepted starts push the expected
// read and write events (cycle, address) into queues; a monitor pops and
// compares every cycle, one time unit after the rising edge.
module tb_addr_sweep_gen;

    localparam int AW  = 11;
    localparam int LAT = 8;
    localparam int INF = 32'h7fff_ffff;

    logic          pll_clock = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [AW:0]   num_ops   = '0;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_e, wr_e, busy, done;

    addr_sweep_gen #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .start     (start),
        .num_ops   (num_ops),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_e      (rd_e),
        .wr_addr   (wr_addr),
        .wr_e      (wr_e),
        .busy      (busy),
        .done      (done)
    );

    always #5 pll_clock = ~pll_clock;

    int cyc = 0;
    always @(posedge pll_clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t rdq[$];
    ev_t wrq[$];
    int  run_lo = 1, run_hi = 0;
    int  busy_lo = 1, busy_hi = 0;
    int  done_from = INF;
    int  last_rd = 0, last_wr = 0;
    int  rd_pulses = 0, wr_pulses = 0, last_rd_seen = 0;
    int  n_cmp = 0, n_bad = 0;

    task automatic cmp(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: actual=%0h required=%0h", name, c, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_start(input int k, input int n);
        int nn;
        if (k >= busy_lo && k <= busy_hi) return;
        nn = (n > (1 << AW)) ? (1 << AW) : n;
        if (nn == 0) begin
            done_from = k + 1;
            return;
        end
        for (int t = 1; t <= nn; t++) begin
            rdq.push_back('{cyc: k + t, addr: t - 1});
            wrq.push_back('{cyc: k + t + LAT, addr: t - 1});
        end
        run_lo    = k + 1;
        run_hi    = k + nn;
        busy_lo   = k + 1;
        busy_hi   = k + nn + LAT;
        done_from = k + nn + LAT + 1;
    endtask

    task automatic model_abort(input int j);
        if (j < run_lo || j > run_hi) return;
        run_hi = j;
        while (rdq.size() > 0 && rdq[$].cyc > j) void'(rdq.pop_back());
        while (wrq.size() > 0 && wrq[$].cyc > j + LAT) void'(wrq.pop_back());
        busy_hi   = j + LAT;
        done_from = j + LAT + 1;
    endtask

    task automatic model_reset();
        rdq.delete();
        wrq.delete();
        run_lo = 1; run_hi = 0;
        busy_lo = 1; busy_hi = 0;
        done_from = INF;
        last_rd = 0; last_wr = 0;
    endtask

    // ---------------- monitor ----------------
    task automatic check_cycle(input int c);
        int er, ea, ew, eb;
        er = 0; ea = last_rd;
        if (rdq.size() > 0 && rdq[0].cyc == c) begin
            er = 1; ea = rdq[0].addr; last_rd = ea;
            void'(rdq.pop_front());
        end
        ew = 0; eb = last_wr;
        if (wrq.size() > 0 && wrq[0].cyc == c) begin
            ew = 1; eb = wrq[0].addr; last_wr = eb;
            void'(wrq.pop_front());
        end
        cmp("rd_e", c, 32'(rd_e), 32'(er));
        cmp("rd_addr", c, 32'(rd_addr), 32'(ea));
        cmp("wr_e", c, 32'(wr_e), 32'(ew));
        cmp("wr_addr", c, 32'(wr_addr), 32'(eb));
        cmp("busy", c, 32'(busy), 32'(c >= busy_lo && c <= busy_hi));
        cmp("done", c, 32'(done), 32'(c >= done_from));
        if (rd_e === 1'b1) begin
            rd_pulses++;
            last_rd_seen = int'(rd_addr);
        end
        if (wr_e === 1'b1) wr_pulses++;
    endtask

    always @(posedge pll_clock) begin
        #1;
        check_cycle(cyc);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input int n, input logic a);
        @(negedge pll_clock);
        start   = s;
        num_ops = (AW+1)'(n);
        abort   = a;
        if (s) model_start(cyc, n);
        if (a) model_abort(cyc);
    endtask

    task automatic idle(input int m);
        repeat (m) drive(1'b0, 0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge pll_clock);
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        model_reset();
        repeat (3) @(posedge pll_clock);
        @(negedge pll_clock);
        reset_n = 1'b1;
    endtask

    task automatic clear_counts();
        rd_pulses = 0;
        wr_pulses = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held across three edges, then twenty quiet cycles.
        repeat (3) @(posedge pll_clock);
        @(negedge pll_clock);
        reset_n = 1'b1;
        idle(20);

        // Basic sweep of five.
        clear_counts();
        drive(1'b1, 5, 1'b0);
        idle(LAT + 10);
        cmp("basic_rd_count", cyc, rd_pulses, 5);
        cmp("basic_wr_count", cyc, wr_pulses, 5);

        // Zero length.
        clear_counts();
        drive(1'b1, 0, 1'b0);
        idle(5);
        cmp("zero_rd_count", cyc, rd_pulses, 0);
        cmp("zero_wr_count", cyc, wr_pulses, 0);

        // Full size and clamped size.
        clear_counts();
        drive(1'b1, 2048, 1'b0);
        idle(2048 + LAT + 4);
        cmp("full_rd_count", cyc, rd_pulses, 2048);
        cmp("full_last_addr", cyc, last_rd_seen, 32'h7FF);
        clear_counts();
        drive(1'b1, 4000, 1'b0);
        idle(2048 + LAT + 4);
        cmp("clamp_rd_count", cyc, rd_pulses, 2048);
        cmp("clamp_wr_count", cyc, wr_pulses, 2048);

        // Abort while address 7 is on the bus.
        clear_counts();
        drive(1'b1, 100, 1'b0);
        idle(7);
        drive(1'b0, 0, 1'b1);
        idle(LAT + 6);
        cmp("abort_rd_count", cyc, rd_pulses, 8);
        cmp("abort_last_addr", cyc, last_rd_seen, 7);
        cmp("abort_wr_count", cyc, wr_pulses, 8);

        // Start while busy is ignored; start after done runs.
        clear_counts();
        drive(1'b1, 10, 1'b0);
        idle(4);
        drive(1'b1, 3, 1'b0);
        idle(LAT + 15);
        cmp("busy_start_rd_count", cyc, rd_pulses, 10);
        clear_counts();
        drive(1'b1, 3, 1'b0);
        idle(LAT + 8);
        cmp("restart_rd_count", cyc, rd_pulses, 3);

        // Reset with four writes in flight.
        drive(1'b1, 20, 1'b0);
        idle(3);
        pulse_reset();
        clear_counts();
        idle(20);
        cmp("reset_wr_count", cyc, wr_pulses, 0);
        drive(1'b1, 3, 1'b0);
        idle(LAT + 8);
        cmp("post_reset_wr_count", cyc, wr_pulses, 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic s, a;
            int   n;
            s = ($urandom_range(0, 14) == 0);
            a = ($urandom_range(0, 24) == 0);
            n = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4095))
                                             : int'($urandom_range(0, 25));
            drive(s, n, a);
        end
        idle(2048 + LAT + 10);
        cmp("final_rdq_empty", cyc, rdq.size(), 0);
        cmp("final_wrq_empty", cyc, wrq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
